// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals around the arbiter.
// Latency: none (wires only).
// Backpressure: none; completion is signalled by the *_resp pulses.
interface mem_arbiter_if #(
  parameter int LINE_W = 128
);
  // Instruction cache side
  logic              i_read;
  logic [15:0]       i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // Data cache side
  logic              d_read;
  logic              d_write;
  logic [15:0]       d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Physical memory side
  logic              pmem_read;
  logic              pmem_write;
  logic [15:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter view
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Environment view (caches plus physical memory)
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical memory between I-cache and D-cache.
// Latency: one cycle from request sampled in IDLE to pmem command; one IDLE cycle between grants.
// Backpressure: a grant is held until pmem_resp; requests are not preempted.
module mem_arbiter #(
  parameter int LINE_W = 128
) (
  input logic       clk,
  input logic       rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = I-cache granted last, 1 = D-cache granted last

  logic i_req;
  logic d_req;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Grant selection and release; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            // Contested: give it to whoever did not win last time.
            if (last_grant) begin
              state      <= GRANT_I;
              last_grant <= 1'b0;
            end else begin
              state      <= GRANT_D;
              last_grant <= 1'b1;
            end
          end else if (i_req) begin
            state      <= GRANT_I;
            last_grant <= 1'b0;
          end else if (d_req) begin
            state      <= GRANT_D;
            last_grant <= 1'b1;
          end
        end
        GRANT_I: if (bus.pmem_resp) state <= IDLE;
        GRANT_D: if (bus.pmem_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data and write data pass straight through; only commands are steered.
  assign bus.i_rdata    = bus.pmem_rdata[LINE_W-1:0];
  assign bus.d_rdata    = bus.pmem_rdata[LINE_W-1:0];
  assign bus.pmem_wdata = bus.d_wdata[LINE_W-1:0];

  // Steer commands and completion pulses to the side that currently owns memory.
  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = bus.i_address;
    bus.i_resp       = 1'b0;
    bus.d_resp       = 1'b0;
    case (state)
      GRANT_I: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = bus.i_address;
        bus.i_resp       = bus.pmem_resp;
      end
      GRANT_D: begin
        // A write-back wins if the D-cache raises both read and write.
        bus.pmem_write   = bus.d_write;
        bus.pmem_read    = bus.d_read & ~bus.d_write;
        bus.pmem_address = bus.d_address;
        bus.d_resp       = bus.pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_W(LW)) bus();
  mem_arbiter #(.LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: who owns memory (0 none, 1 I, 2 D) and who won last (0 I, 1 D).
  int m_owner = 0;
  int m_last  = 0;

  // Outputs observed in the most recent cycle, for directed checks.
  logic          o_pread, o_pwrite, o_iresp, o_dresp;
  logic [15:0]   o_paddr;
  logic [LW-1:0] o_pwdata, o_irdata, o_drdata;

  localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] PAT_0F = {16{8'h0F}};
  localparam logic [LW-1:0] PAT_3C = {16{8'h3C}};

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs against the model,
  // then advance the model to what the rising edge should produce.
  task automatic cyc(input logic r, input logic ir, input logic [15:0] ia,
                     input logic dr, input logic dw, input logic [15:0] da,
                     input logic [LW-1:0] wd, input logic pr, input logic [LW-1:0] rd);
    logic e_pread, e_pwrite, e_iresp, e_dresp;
    @(negedge clk);
    rst = r;
    bus.i_read = ir; bus.i_address = ia;
    bus.d_read = dr; bus.d_write = dw; bus.d_address = da; bus.d_wdata = wd;
    bus.pmem_resp = pr; bus.pmem_rdata = rd;
    #1;
    o_pread = bus.pmem_read;  o_pwrite = bus.pmem_write;
    o_iresp = bus.i_resp;     o_dresp  = bus.d_resp;
    o_paddr = bus.pmem_address; o_pwdata = bus.pmem_wdata;
    o_irdata = bus.i_rdata;   o_drdata = bus.d_rdata;

    e_pread  = (m_owner == 1) || (m_owner == 2 && dr && !dw);
    e_pwrite = (m_owner == 2) && dw;
    e_iresp  = (m_owner == 1) && pr;
    e_dresp  = (m_owner == 2) && pr;
    check("pmem_read", o_pread, e_pread);
    check("pmem_write", o_pwrite, e_pwrite);
    check("i_resp", o_iresp, e_iresp);
    check("d_resp", o_dresp, e_dresp);
    check("pmem_wdata", o_pwdata, wd);
    check("i_rdata", o_irdata, rd);
    check("d_rdata", o_drdata, rd);
    if (m_owner == 1) check("pmem_address_i", o_paddr, ia);
    if (m_owner == 2) check("pmem_address_d", o_paddr, da);

    if (r) begin
      m_owner = 0;
      m_last  = 0;
    end else if (m_owner == 0) begin
      if (ir && (dr || dw)) m_owner = (m_last == 0) ? 2 : 1;
      else if (ir)          m_owner = 1;
      else if (dr || dw)    m_owner = 2;
      if (m_owner != 0) m_last = (m_owner == 2) ? 1 : 0;
    end else if (pr) begin
      m_owner = 0;
    end
  endtask

  initial begin
    // Initial reset: outputs are unknown until the first edge, so no checks here.
    rst = 1'b1;
    bus.i_read = 0; bus.i_address = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = 0; bus.d_wdata = '0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
    @(posedge clk);
    @(posedge clk);

    // Reset state: idle, and a stray pmem_resp produces nothing.
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000, '0, 1, PAT_3C);
    check("reset_pread", o_pread, 1'b0);
    check("reset_iresp", o_iresp, 1'b0);

    // Single I-cache fill.
    cyc(0, 1, 16'h1230, 0, 0, 16'h0000, '0, 0, '0);
    check("i_idle_pread", o_pread, 1'b0);
    cyc(0, 1, 16'h1230, 0, 0, 16'h0000, '0, 0, '0);
    check("i_cmd_pread", o_pread, 1'b1);
    check("i_cmd_addr", o_paddr, 16'h1230);
    cyc(0, 1, 16'h1230, 0, 0, 16'h0000, '0, 1, PAT_A5);
    check("i_resp_pulse", o_iresp, 1'b1);
    check("i_rdata", o_irdata, PAT_A5);
    check("i_no_dresp", o_dresp, 1'b0);
    cyc(0, 0, 16'h1230, 0, 0, 16'h0000, '0, 0, '0);
    check("i_resp_done", o_iresp, 1'b0);

    // After reset, a contested request goes to D first, then I after one idle cycle.
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000, '0, 0, '0);
    cyc(0, 1, 16'h1000, 1, 0, 16'h2000, '0, 0, '0);
    cyc(0, 1, 16'h1000, 1, 0, 16'h2000, '0, 1, PAT_3C);
    check("rr_first_d", o_paddr, 16'h2000);
    check("rr_first_dresp", o_dresp, 1'b1);
    cyc(0, 1, 16'h1000, 0, 0, 16'h2000, '0, 0, '0);
    check("rr_gap_idle", o_pread, 1'b0);
    cyc(0, 1, 16'h1000, 0, 0, 16'h2000, '0, 1, PAT_A5);
    check("rr_then_i", o_paddr, 16'h1000);

    // Both held continuously: grants alternate D, I, D, I.
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000, '0, 0, '0);
    for (int t = 0; t < 4; t++) begin
      cyc(0, 1, 16'h1000, 1, 0, 16'h2000, '0, 0, '0);
      cyc(0, 1, 16'h1000, 1, 0, 16'h2000, '0, 1, PAT_3C);
      check("alternate_grant", o_paddr, (t % 2 == 0) ? 16'h2000 : 16'h1000);
    end

    // D-cache write-back, then read and write together.
    cyc(0, 0, 16'h0000, 0, 1, 16'h4440, PAT_0F, 0, '0);
    cyc(0, 0, 16'h0000, 0, 1, 16'h4440, PAT_0F, 0, '0);
    check("wb_pwrite", o_pwrite, 1'b1);
    check("wb_pread", o_pread, 1'b0);
    check("wb_addr", o_paddr, 16'h4440);
    check("wb_wdata", o_pwdata, PAT_0F);
    cyc(0, 0, 16'h0000, 0, 1, 16'h4440, PAT_0F, 1, '0);
    cyc(0, 0, 16'h0000, 1, 1, 16'h4450, PAT_0F, 0, '0);
    cyc(0, 0, 16'h0000, 1, 1, 16'h4450, PAT_0F, 0, '0);
    check("rw_pwrite", o_pwrite, 1'b1);
    check("rw_pread", o_pread, 1'b0);
    cyc(0, 0, 16'h0000, 1, 1, 16'h4450, PAT_0F, 1, '0);

    // No preemption: I grant survives dropping i_read and raising d_read.
    cyc(0, 1, 16'h1230, 0, 0, 16'h5000, '0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 16'h1230, 1, 0, 16'h5000, '0, 0, '0);
      check("nopreempt_addr", o_paddr, 16'h1230);
    end
    cyc(0, 0, 16'h1230, 1, 0, 16'h5000, '0, 1, PAT_A5);
    check("nopreempt_iresp", o_iresp, 1'b1);
    cyc(0, 0, 16'h1230, 0, 0, 16'h5000, '0, 0, '0);

    // Reset in the middle of a D grant drops it; a late pmem_resp is ignored.
    cyc(0, 0, 16'h0000, 1, 0, 16'h6000, '0, 0, '0);
    cyc(0, 0, 16'h0000, 1, 0, 16'h6000, '0, 0, '0);
    check("midrst_granted", o_pread, 1'b1);
    cyc(1, 0, 16'h0000, 1, 0, 16'h6000, '0, 0, '0);
    cyc(0, 0, 16'h0000, 0, 0, 16'h6000, '0, 1, PAT_3C);
    check("midrst_pread", o_pread, 1'b0);
    check("midrst_dresp", o_dresp, 1'b0);
    cyc(0, 1, 16'h7000, 0, 0, 16'h6000, '0, 0, '0);
    cyc(0, 1, 16'h7000, 0, 0, 16'h6000, '0, 0, '0);
    check("midrst_idle_then_i", o_paddr, 16'h7000);
    cyc(0, 1, 16'h7000, 0, 0, 16'h6000, '0, 1, '0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [LW-1:0] wd, rd;
      wd = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 2) != 0), 16'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 16'($urandom),
          wd, ($urandom_range(0, 2) == 0), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 128, meaning cache-line data width in bits (one lc3b_data).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_read  input  1  instruction-cache line-fill request.
REQ-005 SHALL have port i_address  input  16  instruction line address (lc3b_word).
REQ-006 SHALL have port i_rdata  output  LINE_W  fill data returned to the instruction cache.
REQ-007 SHALL have port i_resp  output  1  one-cycle completion pulse to the instruction cache.
REQ-008 SHALL have ports d_read, d_write  input  1 each  data-cache read and write-back requests.
REQ-009 SHALL have port d_address  input  16  data line address.
REQ-010 SHALL have port d_wdata  input  LINE_W  write-back line data.
REQ-011 SHALL have ports d_rdata  output  LINE_W, and d_resp  output  1  data returned to and completion pulse for the data cache.
REQ-012 SHALL have ports pmem_read, pmem_write  output  1 each  physical-memory commands.
REQ-013 SHALL have ports pmem_address  output  16, and pmem_wdata  output  LINE_W  physical-memory address and write data.
REQ-014 SHALL have ports pmem_rdata  input  LINE_W, and pmem_resp  input  1  physical-memory data and completion pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, GRANT_I and GRANT_D, plus a 1-bit last_grant register (0 = I, 1 = D).
REQ-016 SHALL, in IDLE, evaluate requests: i_req = i_read; d_req = d_read | d_write.
REQ-017 SHALL, in IDLE with exactly one request, enter the matching GRANT state on the next edge.
REQ-018 SHALL, in IDLE with both requests, grant the requester not equal to last_grant (round-robin).
REQ-019 SHALL, in IDLE with no request, remain in IDLE.
REQ-020 SHALL load last_grant with the granted side on every IDLE->GRANT transition.
REQ-021 SHALL, in IDLE, drive pmem_read = pmem_write = 0 and i_resp = d_resp = 0; a pmem_resp arriving in IDLE is ignored.
REQ-022 SHALL, in GRANT_I, drive pmem_read = 1, pmem_write = 0 and pmem_address = i_address.
REQ-023 SHALL, in GRANT_D, drive pmem_address = d_address, pmem_wdata = d_wdata, pmem_write = d_write, and pmem_read = d_read & ~d_write (write wins if both are asserted).
REQ-024 SHALL drive pmem_wdata = d_wdata in all states; it has no effect unless pmem_write = 1.
REQ-025 SHALL drive i_rdata and d_rdata from pmem_rdata in all states.
REQ-026 SHALL assert i_resp = pmem_resp only in GRANT_I, and d_resp = pmem_resp only in GRANT_D; the non-granted resp is held at 0.
REQ-027 SHALL return from GRANT_x to IDLE on the edge where pmem_resp = 1; otherwise it holds the grant indefinitely.
REQ-028 SHALL NOT preempt a grant: a new request, or withdrawal of the granted request, is ignored until pmem_resp.
REQ-029 SHALL have a latency of one cycle from request (sampled in IDLE) to pmem command.
REQ-030 SHALL insert exactly one IDLE cycle between back-to-back transactions.
REQ-031 SHALL have all pmem_* and *_resp outputs combinational from state and inputs, with no registered data path.

Reset
REQ-032 SHALL, when rst = 1 at a rising edge, set state = IDLE and last_grant = 0 (I), so the first contested request goes to D.
REQ-033 SHALL, on reset mid-transaction, drop the grant: pmem_read and pmem_write are 0 from the cycle after the reset edge, and a late pmem_resp produces no i_resp or d_resp.
REQ-034 SHALL give rst priority over every other transition.

Verification
REQ-035 SHALL be verified by: after reset, assert i_read with i_address = 0x1230 -> pmem_read = 1 and pmem_address = 0x1230 next cycle; pmem_resp with pmem_rdata = 0xA5.. -> i_resp = 1 for one cycle with i_rdata = 0xA5..; d_resp stays 0.
REQ-036 SHALL be verified by: after reset, assert i_read and d_read together -> GRANT_D first; after its pmem_resp, one IDLE cycle, then GRANT_I.
REQ-037 SHALL be verified by: hold i_read and d_read continuously for 4 transactions -> grants alternate D, I, D, I; neither side starves.
REQ-038 SHALL be verified by: assert d_write with d_address = 0x4440 and d_wdata = 0x0F.. -> pmem_write = 1, pmem_read = 0, and pmem_address and pmem_wdata match; with d_read and d_write both high -> pmem_write = 1 and pmem_read = 0.
REQ-039 SHALL be verified by: during GRANT_I, drop i_read and raise d_read -> pmem_address stays i_address until pmem_resp.
REQ-040 SHALL be verified by: during GRANT_D, pulse rst, then pulse pmem_resp -> pmem_read = 0 after the reset edge, no d_resp, and the state is IDLE.
